rx_frame_deframer: RTL

//  Consumes the decoded 8-bit byte stream at the end of the RX path. Hunts a 16-bit sync word,

---
 rtl/rx_frame_deframer_pkg.sv | 20 ++
 rtl/rx_frame_deframer_if.sv | 23 ++
 rtl/rx_frame_deframer_crc8.sv | 20 ++
 rtl/rx_frame_deframer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/rx_frame_deframer_pkg.sv
// Shared types and defaults for the RX frame deframer.
package rx_frame_deframer_pkg;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hB54E;
  localparam int unsigned MAX_LEN_DEF   = 64;
  localparam logic [7:0]  CRC_POLY_DEF  = 8'h07;

  typedef enum logic [1:0] {
    StHunt,
    StLen,
    StPayload,
    StCrc
  } state_t;

  // Saturating 16-bit increment for the frame counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rx_frame_deframer_if.sv
// Byte-stream handshake bundle: input AXIS slave side and output AXIS master side.
interface rx_frame_deframer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_crc_ok;
  logic       out_ready;

  // Deframer view.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_crc_ok
  );

  // Byte source / payload sink view.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_crc_ok
  );
endinterface

// File: rtl/rx_frame_deframer_crc8.sv
// Combinational CRC-8 update by one byte, MSB first, no reflection.
module crc8_byte #(
  parameter logic [7:0] POLY = 8'h07
) (
  input  logic [7:0] i_crc,
  input  logic [7:0] i_data,
  output logic [7:0] o_crc
);

  // Eight serial shift/xor steps unrolled.
  always_comb begin
    logic [7:0] w_crc;
    w_crc = i_crc ^ i_data;
    for (int b = 0; b < 8; b++) begin
      w_crc = w_crc[7] ? ((w_crc << 1) ^ POLY) : (w_crc << 1);
    end
    o_crc = w_crc;
  end

endmodule

// File: rtl/rx_frame_deframer.sv
// Sync-hunting frame deframer: sync word, length byte, payload, CRC-8 byte.
// Payload goes out as AXIS with a one-byte hold so the last byte can carry the CRC verdict.
module rx_frame_deframer
  import rx_frame_deframer_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int unsigned MAX_LEN   = MAX_LEN_DEF,
  parameter logic [7:0]  CRC_POLY  = CRC_POLY_DEF
) (
  input  logic                clk,
  input  logic                rst,
  rx_frame_deframer_if.slave  bus,
  output logic [15:0]         frame_ok_cnt,
  output logic [15:0]         frame_err_cnt
);

  state_t      r_state, w_state_next;
  logic [7:0]  r_prev, r_len, r_cnt, r_crc, r_hold;
  logic        r_hold_vld;
  logic        r_out_valid, r_out_last, r_out_crc_ok;
  logic [7:0]  r_out_data;
  logic [15:0] r_ok_cnt, r_err_cnt;

  logic        w_in_ready, w_acc, w_out_hs, w_sync_hit, w_len_ok, w_crc_match, w_load;
  logic [7:0]  w_crc_seed, w_crc_next;

  assign w_out_hs    = r_out_valid && bus.out_ready;
  assign w_acc       = bus.in_valid && w_in_ready;
  assign w_sync_hit  = ({r_prev, bus.in_data} == SYNC_WORD);
  assign w_len_ok    = (bus.in_data != 8'd0) && (32'(bus.in_data) <= MAX_LEN);
  assign w_crc_match = (r_crc == bus.in_data);
  // The length byte starts a fresh CRC; payload bytes extend the running one.
  assign w_crc_seed  = (r_state == StLen) ? 8'h00 : r_crc;
  // The CRC state always has a held byte since LEN >= 1.
  assign w_load      = w_acc && ((r_state == StPayload && r_hold_vld) || r_state == StCrc);

  crc8_byte #(.POLY(CRC_POLY)) u_crc (
    .i_crc  (w_crc_seed),
    .i_data (bus.in_data),
    .o_crc  (w_crc_next)
  );

  // Next-state and input-side ready.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b1;
    unique case (r_state)
      StHunt:    if (w_acc && w_sync_hit) w_state_next = StLen;
      StLen:     if (w_acc) w_state_next = w_len_ok ? StPayload : StHunt;
      StPayload: begin
        w_in_ready = !r_out_valid || bus.out_ready;
        if (w_acc && r_cnt == r_len - 8'd1) w_state_next = StCrc;
      end
      StCrc: begin
        w_in_ready = !r_out_valid || bus.out_ready;
        if (w_acc) w_state_next = StHunt;
      end
      default:   w_state_next = StHunt;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StHunt;
    else     r_state <= w_state_next;
  end

  // Sync shift byte; cleared outside HUNT so a sync never spans two frames.
  always_ff @(posedge clk) begin
    if (rst || r_state != StHunt) r_prev <= 8'h00;
    else if (w_acc)               r_prev <= w_sync_hit ? 8'h00 : bus.in_data;
  end

  // Length, byte counter, running CRC and one-byte hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len      <= 8'd0;
      r_cnt      <= 8'd0;
      r_crc      <= 8'h00;
      r_hold     <= 8'h00;
      r_hold_vld <= 1'b0;
    end else if (w_acc) begin
      if (r_state == StLen && w_len_ok) begin
        r_len <= bus.in_data;
        r_cnt <= 8'd0;
        r_crc <= w_crc_next;
      end else if (r_state == StPayload) begin
        r_cnt      <= r_cnt + 8'd1;
        r_crc      <= w_crc_next;
        r_hold     <= bus.in_data;
        r_hold_vld <= 1'b1;
      end else if (r_state == StCrc) begin
        r_hold_vld <= 1'b0;
      end
    end
  end

  // Output register: load from hold, otherwise drop valid after a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= 8'h00;
      r_out_last   <= 1'b0;
      r_out_crc_ok <= 1'b0;
    end else if (w_load) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= r_hold;
      r_out_last   <= (r_state == StCrc);
      r_out_crc_ok <= (r_state == StCrc) && w_crc_match;
    end else if (w_out_hs) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Saturating frame counters; length rejects count as errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ok_cnt  <= 16'd0;
      r_err_cnt <= 16'd0;
    end else if (w_acc) begin
      if (r_state == StCrc && w_crc_match) r_ok_cnt <= sat_inc(r_ok_cnt);
      if ((r_state == StCrc && !w_crc_match) || (r_state == StLen && !w_len_ok)) begin
        r_err_cnt <= sat_inc(r_err_cnt);
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_last   = r_out_last;
  assign bus.out_crc_ok = r_out_crc_ok;
  assign frame_ok_cnt   = r_ok_cnt;
  assign frame_err_cnt  = r_err_cnt;

endmodule
